// File: rtl/tick_scheduler_pkg.sv
// Shared constants and channel state encoding for the millisecond tick scheduler.
// The tick generator also uses TICKS_PER_MS, so keep it in step with the board clock.
package tick_sched_pkg;

    localparam int NUM_CH_DEF   = 4;
    localparam int PER_W_DEF    = 16;
    localparam int TICKS_PER_MS = 50000;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_e;

endpackage

// File: rtl/tick_scheduler_if.sv
// Configuration, ack and status bundle between game logic (master) and the scheduler (slave).
interface tick_scheduler_if #(
    parameter int NUM_CH = 4,
    parameter int PER_W  = 16
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              tick_1ms;
    logic              pause;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [PER_W-1:0]  cfg_period;
    logic              cfg_en;
    logic              cfg_oneshot;
    logic [NUM_CH-1:0] ack;
    logic [NUM_CH-1:0] fire;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] overrun;
    logic [NUM_CH-1:0] active;

    modport master (
        output tick_1ms, pause, cfg_we, cfg_ch, cfg_period, cfg_en, cfg_oneshot, ack,
        input  fire, pending, overrun, active
    );

    modport slave (
        input  tick_1ms, pause, cfg_we, cfg_ch, cfg_period, cfg_en, cfg_oneshot, ack,
        output fire, pending, overrun, active
    );

endinterface

// File: rtl/tick_scheduler_channel.sv
// One scheduler channel: period counter, IDLE/RUN state, sticky pending/overrun flags.
// All outputs are registered; a config write always overrides a same-cycle expiry.
module sched_channel
    import tick_sched_pkg::*;
#(
    parameter int PER_W = PER_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_i,
    input  logic             pause_i,
    input  logic             we_i,
    input  logic [PER_W-1:0] period_i,
    input  logic             en_i,
    input  logic             oneshot_i,
    input  logic             ack_i,
    output logic             fire_o,
    output logic             pending_o,
    output logic             overrun_o,
    output logic             active_o
);

    ch_state_e        state_q, state_d;
    logic [PER_W-1:0] cnt_q, cnt_d;
    logic [PER_W-1:0] period_q, period_d;
    logic             oneshot_q, oneshot_d;
    logic             fire_q, fire_d;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic             advance;
    logic             expire;

    // An ack is ignored while an expiry is being set or its fire pulse is visible: set wins.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        oneshot_d = oneshot_q;
        fire_d    = 1'b0;
        pending_d = pending_q;
        overrun_d = overrun_q;
        advance   = (state_q == RUN) && tick_i && !pause_i;
        expire    = advance && (cnt_q == period_q - PER_W'(1));

        if (we_i) begin
            period_d  = period_i;
            oneshot_d = oneshot_i;
            cnt_d     = '0;
            pending_d = 1'b0;
            overrun_d = 1'b0;
            state_d   = (en_i && (period_i != '0)) ? RUN : IDLE;
        end else begin
            if (expire) begin
                cnt_d     = '0;
                fire_d    = 1'b1;
                pending_d = 1'b1;
                if (pending_q && !ack_i) overrun_d = 1'b1;
                if (oneshot_q) state_d = IDLE;
            end else if (advance) begin
                cnt_d = cnt_q + PER_W'(1);
            end
            if (ack_i && !expire && !fire_q) pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            oneshot_q <= 1'b0;
            fire_q    <= 1'b0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            oneshot_q <= oneshot_d;
            fire_q    <= fire_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign fire_o    = fire_q;
    assign pending_o = pending_q;
    assign overrun_o = overrun_q;
    assign active_o  = (state_q == RUN);

endmodule

// File: rtl/tick_scheduler.sv
// Multi-channel millisecond event scheduler: decodes config writes per channel and
// fans the shared tick and pause out to independent channel instances.
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int PER_W  = PER_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    tick_scheduler_if.slave  bus
);

    logic [NUM_CH-1:0] ch_we;

    // Channel indices beyond NUM_CH match no decode line, so such writes are dropped.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign ch_we[k] = bus.cfg_we && (int'(bus.cfg_ch) == k);

        sched_channel #(
            .PER_W(PER_W)
        ) u_channel (
            .clk       (clk),
            .reset     (reset),
            .tick_i    (bus.tick_1ms),
            .pause_i   (bus.pause),
            .we_i      (ch_we[k]),
            .period_i  (bus.cfg_period),
            .en_i      (bus.cfg_en),
            .oneshot_i (bus.cfg_oneshot),
            .ack_i     (bus.ack[k]),
            .fire_o    (bus.fire[k]),
            .pending_o (bus.pending[k]),
            .overrun_o (bus.overrun[k]),
            .active_o  (bus.active[k])
        );
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed self-checking bench for tick_scheduler: one task per scenario, expected
// values worked out by hand from the channel timing rules.
module tb_tick_scheduler;

    localparam int NUM_CH = 4;
    localparam int PER_W  = 16;

    logic clk;
    logic reset;
    int   pass_cnt;
    int   chk_cnt;

    tick_scheduler_if #(.NUM_CH(NUM_CH), .PER_W(PER_W)) bus();

    tick_scheduler #(
        .NUM_CH(NUM_CH),
        .PER_W (PER_W)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are held across one rising edge; outputs are sampled 1 ns later.
    task automatic clock_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        clock_cycle();
    endtask

    task automatic do_tick();
        bus.tick_1ms = 1'b1;
        clock_cycle();
        bus.tick_1ms = 1'b0;
    endtask

    task automatic cfg_write(input int ch, input int period, input bit en, input bit oneshot);
        bus.cfg_we      = 1'b1;
        bus.cfg_ch      = 2'(ch);
        bus.cfg_period  = 16'(period);
        bus.cfg_en      = en;
        bus.cfg_oneshot = oneshot;
        clock_cycle();
        bus.cfg_we      = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clock_cycle();
        clock_cycle();
        reset = 1'b0;
        clock_cycle();
        chk_cnt++; if (bus.fire !== 4'h0) $display("[TB] FAIL reset_fire: got %b expected 0000", bus.fire); else pass_cnt++;
        chk_cnt++; if (bus.pending !== 4'h0) $display("[TB] FAIL reset_pending: got %b expected 0000", bus.pending); else pass_cnt++;
        chk_cnt++; if (bus.overrun !== 4'h0) $display("[TB] FAIL reset_overrun: got %b expected 0000", bus.overrun); else pass_cnt++;
        chk_cnt++; if (bus.active !== 4'h0) $display("[TB] FAIL reset_active: got %b expected 0000", bus.active); else pass_cnt++;
    endtask

    task automatic test_periodic();
        logic [3:0] exp_fire;
        cfg_write(0, 3, 1'b1, 1'b0);
        for (int t = 1; t <= 10; t++) begin
            do_tick();
            exp_fire = (t % 3 == 0) ? 4'b0001 : 4'b0000;
            chk_cnt++; if (bus.fire !== exp_fire) $display("[TB] FAIL periodic_fire t%0d: got %b expected %b", t, bus.fire, exp_fire); else pass_cnt++;
            chk_cnt++; if (bus.active[0] !== 1'b1) $display("[TB] FAIL periodic_active t%0d: got %b expected 1", t, bus.active[0]); else pass_cnt++;
            idle_cycle();
            chk_cnt++; if (bus.fire !== 4'b0000) $display("[TB] FAIL periodic_fire_width t%0d: got %b expected 0000", t, bus.fire); else pass_cnt++;
        end
        cfg_write(0, 3, 1'b0, 1'b0);
    endtask

    task automatic test_oneshot();
        logic [3:0] exp_fire;
        logic       exp_act;
        cfg_write(1, 2, 1'b1, 1'b1);
        for (int t = 1; t <= 6; t++) begin
            do_tick();
            exp_fire = (t == 2) ? 4'b0010 : 4'b0000;
            exp_act  = (t < 2);
            chk_cnt++; if (bus.fire !== exp_fire) $display("[TB] FAIL oneshot_fire t%0d: got %b expected %b", t, bus.fire, exp_fire); else pass_cnt++;
            chk_cnt++; if (bus.active[1] !== exp_act) $display("[TB] FAIL oneshot_active t%0d: got %b expected %b", t, bus.active[1], exp_act); else pass_cnt++;
            idle_cycle();
        end
        cfg_write(1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_overrun();
        cfg_write(2, 1, 1'b1, 1'b0);
        do_tick();
        chk_cnt++; if (bus.fire !== 4'b0100) $display("[TB] FAIL ovr_fire1: got %b expected 0100", bus.fire); else pass_cnt++;
        chk_cnt++; if (bus.pending[2] !== 1'b1) $display("[TB] FAIL ovr_pending1: got %b expected 1", bus.pending[2]); else pass_cnt++;
        chk_cnt++; if (bus.overrun[2] !== 1'b0) $display("[TB] FAIL ovr_overrun1: got %b expected 0", bus.overrun[2]); else pass_cnt++;
        idle_cycle();
        do_tick();
        chk_cnt++; if (bus.fire !== 4'b0100) $display("[TB] FAIL ovr_fire2: got %b expected 0100", bus.fire); else pass_cnt++;
        chk_cnt++; if (bus.overrun[2] !== 1'b1) $display("[TB] FAIL ovr_overrun2: got %b expected 1", bus.overrun[2]); else pass_cnt++;
        idle_cycle();
        bus.ack = 4'b0100;
        clock_cycle();
        bus.ack = 4'b0000;
        chk_cnt++; if (bus.pending[2] !== 1'b0) $display("[TB] FAIL ovr_ack_pending: got %b expected 0", bus.pending[2]); else pass_cnt++;
        chk_cnt++; if (bus.overrun[2] !== 1'b1) $display("[TB] FAIL ovr_ack_overrun: got %b expected 1", bus.overrun[2]); else pass_cnt++;
        cfg_write(2, 0, 1'b0, 1'b0);
        chk_cnt++; if (bus.overrun[2] !== 1'b0) $display("[TB] FAIL ovr_cfg_clear: got %b expected 0", bus.overrun[2]); else pass_cnt++;
        chk_cnt++; if (bus.active[2] !== 1'b0) $display("[TB] FAIL ovr_cfg_idle: got %b expected 0", bus.active[2]); else pass_cnt++;
    endtask

    task automatic test_pause();
        logic [3:0] exp_fire;
        cfg_write(3, 5, 1'b1, 1'b0);
        for (int t = 1; t <= 2; t++) begin
            do_tick();
            chk_cnt++; if (bus.fire !== 4'b0000) $display("[TB] FAIL pause_pre t%0d: got %b expected 0000", t, bus.fire); else pass_cnt++;
            idle_cycle();
        end
        bus.pause = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            do_tick();
            chk_cnt++; if (bus.fire !== 4'b0000) $display("[TB] FAIL pause_held t%0d: got %b expected 0000", t, bus.fire); else pass_cnt++;
            idle_cycle();
        end
        bus.pause = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            do_tick();
            exp_fire = (t == 3) ? 4'b1000 : 4'b0000;
            chk_cnt++; if (bus.fire !== exp_fire) $display("[TB] FAIL pause_resume t%0d: got %b expected %b", t, bus.fire, exp_fire); else pass_cnt++;
            idle_cycle();
        end
        cfg_write(3, 0, 1'b0, 1'b0);
    endtask

    task automatic test_cfg_collision();
        logic [3:0] exp_fire;
        cfg_write(0, 4, 1'b1, 1'b0);
        for (int t = 1; t <= 3; t++) begin
            do_tick();
            idle_cycle();
        end
        bus.tick_1ms    = 1'b1;
        bus.cfg_we      = 1'b1;
        bus.cfg_ch      = 2'd0;
        bus.cfg_period  = 16'd4;
        bus.cfg_en      = 1'b1;
        bus.cfg_oneshot = 1'b0;
        clock_cycle();
        bus.tick_1ms = 1'b0;
        bus.cfg_we   = 1'b0;
        chk_cnt++; if (bus.fire !== 4'b0000) $display("[TB] FAIL coll_nofire: got %b expected 0000", bus.fire); else pass_cnt++;
        chk_cnt++; if (bus.active[0] !== 1'b1) $display("[TB] FAIL coll_active: got %b expected 1", bus.active[0]); else pass_cnt++;
        idle_cycle();
        for (int t = 1; t <= 4; t++) begin
            do_tick();
            exp_fire = (t == 4) ? 4'b0001 : 4'b0000;
            chk_cnt++; if (bus.fire !== exp_fire) $display("[TB] FAIL coll_restart t%0d: got %b expected %b", t, bus.fire, exp_fire); else pass_cnt++;
            idle_cycle();
        end
        for (int t = 1; t <= 3; t++) begin
            do_tick();
            idle_cycle();
        end
        bus.ack = 4'b0001;
        do_tick();
        bus.ack = 4'b0000;
        chk_cnt++; if (bus.fire !== 4'b0001) $display("[TB] FAIL ackfire_fire: got %b expected 0001", bus.fire); else pass_cnt++;
        chk_cnt++; if (bus.pending[0] !== 1'b1) $display("[TB] FAIL ackfire_pending: got %b expected 1", bus.pending[0]); else pass_cnt++;
        chk_cnt++; if (bus.overrun[0] !== 1'b0) $display("[TB] FAIL ackfire_overrun: got %b expected 0", bus.overrun[0]); else pass_cnt++;
        idle_cycle();
        bus.ack = 4'b0001;
        clock_cycle();
        bus.ack = 4'b0000;
        chk_cnt++; if (bus.pending[0] !== 1'b0) $display("[TB] FAIL ack_clear: got %b expected 0", bus.pending[0]); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        cfg_write(2, 1, 1'b1, 1'b0);
        do_tick();
        idle_cycle();
        do_tick();
        idle_cycle();
        chk_cnt++; if (bus.overrun[2] !== 1'b1) $display("[TB] FAIL rmid_pre_overrun: got %b expected 1", bus.overrun[2]); else pass_cnt++;
        reset        = 1'b1;
        bus.tick_1ms = 1'b1;
        clock_cycle();
        reset        = 1'b0;
        bus.tick_1ms = 1'b0;
        chk_cnt++; if (bus.fire !== 4'h0) $display("[TB] FAIL rmid_fire: got %b expected 0000", bus.fire); else pass_cnt++;
        chk_cnt++; if (bus.pending !== 4'h0) $display("[TB] FAIL rmid_pending: got %b expected 0000", bus.pending); else pass_cnt++;
        chk_cnt++; if (bus.overrun !== 4'h0) $display("[TB] FAIL rmid_overrun: got %b expected 0000", bus.overrun); else pass_cnt++;
        chk_cnt++; if (bus.active !== 4'h0) $display("[TB] FAIL rmid_active: got %b expected 0000", bus.active); else pass_cnt++;
        for (int t = 1; t <= 8; t++) begin
            do_tick();
            chk_cnt++; if (bus.fire !== 4'h0) $display("[TB] FAIL rmid_idle_fire t%0d: got %b expected 0000", t, bus.fire); else pass_cnt++;
            chk_cnt++; if (bus.active !== 4'h0) $display("[TB] FAIL rmid_idle_active t%0d: got %b expected 0000", t, bus.active); else pass_cnt++;
            idle_cycle();
        end
    endtask

    // Run each scenario in order; later scenarios assume earlier ones left channels idle.
    initial begin
        pass_cnt        = 0;
        chk_cnt         = 0;
        reset           = 1'b1;
        bus.tick_1ms    = 1'b0;
        bus.pause       = 1'b0;
        bus.cfg_we      = 1'b0;
        bus.cfg_ch      = '0;
        bus.cfg_period  = '0;
        bus.cfg_en      = 1'b0;
        bus.cfg_oneshot = 1'b0;
        bus.ack         = '0;

        test_reset();
        test_periodic();
        test_oneshot();
        test_overrun();
        test_pause();
        test_cfg_collision();
        test_reset_mid();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
